// File: rtl/dcache_store_port.sv
// Store-side responder of a small direct-mapped, write-back, write-allocate data cache.
// Ports: clk/rst (async active-low); cache_* store request from the store buffer;
// store_success one-cycle retire pulse; mem_* handshaked line writeback/fill port.

`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef SIZE_WRITE_WIDTH
`define SIZE_WRITE_WIDTH 2
`endif
`ifndef FULL_WORD_SIZE
`define FULL_WORD_SIZE 2'd2
`endif
`ifndef BYTE_SIZE
`define BYTE_SIZE 2'd0
`endif

module dcache_store_port #(
    parameter int WORD_SIZE        = `WORD_SIZE,
    parameter int WIDTH            = `ADDRESS_WIDTH,
    parameter int SIZE_WRITE_WIDTH = `SIZE_WRITE_WIDTH,
    parameter int LINES            = 4,
    parameter int LINE_BYTES       = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cache_wenable,
    input  logic [WIDTH-1:0]            cache_physical_address,
    input  logic [WORD_SIZE-1:0]        cache_store_value,
    input  logic [SIZE_WRITE_WIDTH-1:0] cache_store_size,
    output logic                        store_success,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [WIDTH-1:0]            mem_addr,
    output logic [LINE_BYTES*8-1:0]     mem_wdata,
    input  logic                        mem_ready,
    input  logic [LINE_BYTES*8-1:0]     mem_rdata
);

    localparam int OFF   = $clog2(LINE_BYTES);
    localparam int IDX   = $clog2(LINES);
    localparam int TAGW  = WIDTH - OFF - IDX;
    localparam int LBITS = LINE_BYTES * 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACK,
        S_WB,
        S_FILL
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [LINES-1:0]     r_valid;
    logic [LINES-1:0]     r_dirty;
    logic [TAGW-1:0]      r_tag  [LINES];
    logic [LBITS-1:0]     r_data [LINES];

    // Line address of the store whose miss is being serviced.
    logic [WIDTH-OFF-1:0] r_miss_line;
    logic [WIDTH-1:0]     r_mem_addr;
    logic [LBITS-1:0]     r_mem_wdata;

    logic [IDX-1:0]       w_idx;
    logic [TAGW-1:0]      w_tag;
    logic [OFF-1:0]       w_boff;
    logic [WIDTH-OFF-1:0] w_req_line;
    logic                 w_hit;
    logic                 w_victim_dirty;
    logic                 w_is_byte;
    logic [LBITS-1:0]     w_line;
    logic [IDX-1:0]       w_fill_idx;
    logic [TAGW-1:0]      w_fill_tag;

    assign w_idx          = cache_physical_address[OFF+IDX-1:OFF];
    assign w_tag          = cache_physical_address[WIDTH-1:OFF+IDX];
    assign w_boff         = cache_physical_address[OFF-1:0];
    assign w_req_line     = cache_physical_address[WIDTH-1:OFF];
    assign w_hit          = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_victim_dirty = r_valid[w_idx] && r_dirty[w_idx];
    assign w_is_byte      = (cache_store_size == `BYTE_SIZE);
    assign w_fill_idx     = r_miss_line[IDX-1:0];
    assign w_fill_tag     = r_miss_line[WIDTH-OFF-1:IDX];

    // Merge the store into the indexed line; word stores drop addr[1:0].
    always_comb begin
        w_line = r_data[w_idx];
        for (int k = 0; k < LINE_BYTES; k++) begin
            if (w_is_byte) begin
                if (k == int'(w_boff))
                    w_line[8*k +: 8] = cache_store_value[7:0];
            end else if ((k / 4) == int'(w_boff >> 2)) begin
                w_line[8*k +: 8] = cache_store_value[8*(k%4) +: 8];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (cache_wenable) begin
                    if (w_hit)               w_next = S_ACK;
                    else if (w_victim_dirty) w_next = S_WB;
                    else                     w_next = S_FILL;
                end
            end
            S_ACK:  w_next = S_IDLE;
            S_WB:   if (mem_ready) w_next = S_FILL;
            S_FILL: if (mem_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs: handshake strobes follow the state, so an
    // asynchronous reset drops them immediately.
    always_comb begin
        store_success = (r_state == S_ACK);
        mem_req       = (r_state == S_WB) || (r_state == S_FILL);
        mem_we        = (r_state == S_WB);
        mem_addr      = r_mem_addr;
        mem_wdata     = r_mem_wdata;
    end

    // Line status bits and the memory request registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid     <= '0;
            r_dirty     <= '0;
            r_miss_line <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cache_wenable) begin
                        if (w_hit) begin
                            r_dirty[w_idx] <= 1'b1;
                        end else begin
                            r_miss_line <= w_req_line;
                            if (w_victim_dirty) begin
                                r_mem_addr  <= {r_tag[w_idx], w_idx,
                                                {OFF{1'b0}}};
                                r_mem_wdata <= r_data[w_idx];
                            end else begin
                                r_mem_addr  <= {w_req_line, {OFF{1'b0}}};
                            end
                        end
                    end
                end
                S_WB: begin
                    if (mem_ready) begin
                        r_dirty[w_fill_idx] <= 1'b0;
                        r_mem_addr          <= {r_miss_line, {OFF{1'b0}}};
                    end
                end
                S_FILL: begin
                    if (mem_ready) begin
                        r_valid[w_fill_idx] <= 1'b1;
                        r_dirty[w_fill_idx] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Data and tag arrays carry no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && cache_wenable && w_hit) begin
            r_data[w_idx] <= w_line;
        end else if (r_state == S_FILL && mem_ready) begin
            r_data[w_fill_idx] <= mem_rdata;
            r_tag[w_fill_idx]  <= w_fill_tag;
        end
    end

endmodule

// File: tb/tb_dcache_store_port.sv
// Self-checking bench for dcache_store_port: store vector table, memory
// responder with an expected-transaction queue and a golden byte image.

`ifndef SIZE_WRITE_WIDTH
`define SIZE_WRITE_WIDTH 2
`endif
`ifndef FULL_WORD_SIZE
`define FULL_WORD_SIZE 2'd2
`endif
`ifndef BYTE_SIZE
`define BYTE_SIZE 2'd0
`endif

module tb_dcache_store_port;

    logic                         clk = 1'b0;
    logic                         rst = 1'b0;
    logic                         cache_wenable = 1'b0;
    logic [31:0]                  cache_physical_address = '0;
    logic [31:0]                  cache_store_value = '0;
    logic [`SIZE_WRITE_WIDTH-1:0] cache_store_size = `FULL_WORD_SIZE;
    logic                         store_success;
    logic                         mem_req;
    logic                         mem_we;
    logic [31:0]                  mem_addr;
    logic [127:0]                 mem_wdata;
    logic                         mem_ready = 1'b0;
    logic [127:0]                 mem_rdata = '0;

    dcache_store_port #(
        .WORD_SIZE(32),
        .WIDTH(32),
        .SIZE_WRITE_WIDTH(`SIZE_WRITE_WIDTH),
        .LINES(4),
        .LINE_BYTES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cache_wenable(cache_wenable),
        .cache_physical_address(cache_physical_address),
        .cache_store_value(cache_store_value),
        .cache_store_size(cache_store_size),
        .store_success(store_success),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] val;
        bit          isbyte;
        bit          wb;
        logic [31:0] wb_addr;
        bit          fill;
        int          dly;
    } vec_t;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        int          dly;
    } txn_t;

    txn_t         exp_q[$];
    logic [127:0] mem_img [logic [31:0]];
    logic [7:0]   gold    [logic [31:0]];
    vec_t         vecs    [12];

    int n_vec = 0;
    int n_cmp = 0;
    int n_err = 0;
    int fill_done_cyc = 0;
    bit prev_ack = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] gold_line(input logic [31:0] base);
        logic [127:0] l;
        logic [31:0]  a;
        l = '0;
        for (int k = 0; k < 16; k++) begin
            a = base + 32'(k);
            if (gold.exists(a)) l[8*k +: 8] = gold[a];
        end
        return l;
    endfunction

    function automatic logic [127:0] mem_line(input logic [31:0] base);
        if (mem_img.exists(base)) return mem_img[base];
        return '0;
    endfunction

    // Memory side: checks each request against the expected queue,
    // optionally stalls, then completes it unless reset intervenes.
    initial begin : responder
        txn_t        t;
        logic [31:0] a0;
        bit          ab;
        forever begin
            @(negedge clk);
            if (rst && mem_req) begin
                a0 = mem_addr;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_mem_req: got we=%0b addr %0h expected none",
                             mem_we, mem_addr);
                    t = '{we: mem_we, addr: mem_addr, dly: 0};
                end else begin
                    t = exp_q.pop_front();
                end
                chk("mem_we", mem_we, t.we);
                chk("mem_addr", mem_addr, t.addr);
                if (mem_we) chk("wb_data", mem_wdata, gold_line(mem_addr));
                ab = 1'b0;
                for (int i = 0; i < t.dly; i++) begin
                    @(negedge clk);
                    if (!rst) begin
                        ab = 1'b1;
                        break;
                    end
                    chk("stall_req", mem_req, 1);
                    chk("stall_addr", mem_addr, a0);
                    chk("stall_succ", store_success, 0);
                end
                if (!ab) begin
                    if (mem_we) mem_img[mem_addr] = mem_wdata;
                    else        mem_rdata = mem_line(mem_addr);
                    mem_ready = 1'b1;
                    @(negedge clk);
                    mem_ready = 1'b0;
                    if (!t.we) fill_done_cyc = cyc;
                end
            end
        end
    end

    task automatic apply(input vec_t v);
        int  c0;
        int  exp_c;
        bit  seen;
        logic [31:0] wa;
        if (v.wb)   exp_q.push_back('{we: 1'b1, addr: v.wb_addr, dly: 0});
        if (v.fill) exp_q.push_back('{we: 1'b0, addr: v.addr & ~32'hF, dly: v.dly});
        cache_physical_address = v.addr;
        cache_store_value      = v.val;
        cache_store_size       = v.isbyte ? `BYTE_SIZE : `FULL_WORD_SIZE;
        cache_wenable          = 1'b1;
        n_vec++;
        c0    = cyc;
        exp_c = c0 + (prev_ack ? 2 : 1);
        seen  = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (i == 0 && prev_ack) chk("ack_width", store_success, 0);
            if (store_success) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout: got no store_success for addr %0h expected a pulse",
                     v.addr);
        end else begin
            if (v.fill) chk("miss_lat", cyc, fill_done_cyc + 1);
            else        chk("hit_lat", cyc, exp_c);
            chk("txn_drain", exp_q.size(), 0);
            if (v.isbyte) begin
                gold[v.addr] = v.val[7:0];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    wa = (v.addr & ~32'h3) + 32'(b);
                    gold[wa] = v.val[8*b +: 8];
                end
            end
        end
        prev_ack = seen;
    endtask

    initial begin : main
        bit found;
        vecs[0]  = '{32'h100, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,   1'b1, 0};
        vecs[1]  = '{32'h102, 32'h000000AB, 1'b1, 1'b0, 32'h0,   1'b0, 0};
        vecs[2]  = '{32'h140, 32'h11223344, 1'b0, 1'b1, 32'h100, 1'b1, 0};
        vecs[3]  = '{32'h154, 32'h55667788, 1'b0, 1'b0, 32'h0,   1'b1, 5};
        vecs[4]  = '{32'h157, 32'h00000099, 1'b1, 1'b0, 32'h0,   1'b0, 0};
        vecs[5]  = '{32'h101, 32'h0000005C, 1'b1, 1'b1, 32'h140, 1'b1, 1};
        vecs[6]  = '{32'h12C, 32'h0BADF00D, 1'b0, 1'b0, 32'h0,   1'b1, 2};
        vecs[7]  = '{32'h1FF, 32'h0000005A, 1'b1, 1'b0, 32'h0,   1'b1, 0};
        vecs[8]  = '{32'h1C3, 32'h13579BDF, 1'b0, 1'b1, 32'h100, 1'b1, 0};
        vecs[9]  = '{32'h250, 32'h2468ACE0, 1'b0, 1'b1, 32'h150, 1'b1, 3};
        vecs[10] = '{32'h120, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0,   1'b0, 0};
        vecs[11] = '{32'h1F0, 32'h00000077, 1'b1, 1'b0, 32'h0,   1'b0, 0};

        repeat (2) @(negedge clk);
        chk("rst_success", store_success, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) apply(vecs[i]);

        // Reset in the middle of a stalled fill.
        exp_q.push_back('{we: 1'b1, addr: 32'h1C0, dly: 0});
        exp_q.push_back('{we: 1'b0, addr: 32'h100, dly: 40});
        cache_physical_address = 32'h100;
        cache_store_value      = 32'h0F0F0F0F;
        cache_store_size       = `FULL_WORD_SIZE;
        cache_wenable          = 1'b1;
        n_vec++;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mem_req && !mem_we) begin
                found = 1'b1;
                break;
            end
        end
        chk("fill_seen", found, 1);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_req", mem_req, 0);
        chk("async_rst_succ", store_success, 0);
        cache_wenable = 1'b0;
        repeat (2) @(negedge clk);
        rst      = 1'b1;
        prev_ack = 1'b0;
        @(negedge clk);

        // After reset the line is gone: the same store misses again,
        // then a conflicting store evicts it with the new data.
        apply('{32'h100, 32'h0F0F0F0F, 1'b0, 1'b0, 32'h0,   1'b1, 0});
        apply('{32'h140, 32'h00000001, 1'b0, 1'b1, 32'h100, 1'b1, 2});

        cache_wenable = 1'b0;
        @(negedge clk);
        chk("final_ack_width", store_success, 0);
        @(negedge clk);
        chk("final_idle_succ", store_success, 0);
        chk("final_idle_req", mem_req, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
